// File: rtl/gyro_bias_calibrator.sv
// ============================================================================
// Module   : gyro_bias_calibrator
// Purpose  : Averages 2^LOG2_SAMPLES samples per channel into a zero-rate bias,
//            then streams saturated (sample - bias) with one cycle of latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gyro_bias_calibrator #(
    parameter int CHANNELS     = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_SAMPLES = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           cal_start_in,
    input  logic                           sample_valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] sample_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] corrected_out,
    output logic                           corrected_valid_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] bias_out,
    output logic                           busy_out,
    output logic                           cal_done_out
);

    localparam int ACC_W = DATA_WIDTH + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = {1'b0, {LOG2_SAMPLES{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_CAL    = 2'd3
    } state_t;

    state_t                        r_state;
    logic                          r_cal_d;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_cvalid;
    logic [CNT_W-1:0]              r_cnt;
    logic signed [ACC_W-1:0]       r_acc  [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_bias [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_corr [CHANNELS];

    logic                          w_start;
    logic signed [DATA_WIDTH-1:0]  w_samp [CHANNELS];
    logic signed [DATA_WIDTH:0]    w_diff [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  w_sat  [CHANNELS];

    assign w_start = cal_start_in & ~r_cal_d;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            assign w_samp[k] = $signed(sample_in[k*DATA_WIDTH +: DATA_WIDTH]);
            assign w_diff[k] = {w_samp[k][DATA_WIDTH-1], w_samp[k]}
                             - {r_bias[k][DATA_WIDTH-1], r_bias[k]};
            // Top two bits disagree only when the difference left the output range
            assign w_sat[k]  = (w_diff[k][DATA_WIDTH] != w_diff[k][DATA_WIDTH-1])
                             ? (w_diff[k][DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                             : w_diff[k][DATA_WIDTH-1:0];
            assign corrected_out[k*DATA_WIDTH +: DATA_WIDTH] = r_corr[k];
            assign bias_out[k*DATA_WIDTH +: DATA_WIDTH]      = r_bias[k];
        end
    endgenerate

    assign corrected_valid_out = r_cvalid;
    assign busy_out            = r_busy;
    assign cal_done_out        = r_done;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_cal_d  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cvalid <= 1'b0;
            r_cnt    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_acc[k]  <= '0;
                r_bias[k] <= '0;
                r_corr[k] <= '0;
            end
        end else begin
            r_cal_d  <= cal_start_in;
            r_cvalid <= sample_valid_in;
            if (sample_valid_in) begin
                for (int k = 0; k < CHANNELS; k++) r_corr[k] <= w_sat[k];
            end

            case (r_state)
                S_IDLE, S_CAL: begin
                    // Old bias stays applied while a recalibration accumulates
                    if (w_start) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                        for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_start) begin
                        r_cnt <= '0;
                        for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
                    end else if (sample_valid_in) begin
                        for (int k = 0; k < CHANNELS; k++)
                            r_acc[k] <= r_acc[k] + ACC_W'(w_samp[k]);
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_cnt_last) r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    for (int k = 0; k < CHANNELS; k++)
                        r_bias[k] <= DATA_WIDTH'(r_acc[k] >>> LOG2_SAMPLES);
                    r_state <= S_CAL;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
